aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_rk_store.sv | 44 ++++
 rtl/aes_key_sched_ctrl.sv | 89 ++++++++
 tb/tb_aes_key_sched_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key-schedule controller.
package aes_pkg;

  localparam int unsigned AES_NR  = 10;
  localparam int unsigned AES_NRK = 11;
  localparam logic [3:0]  AES_NR_IDX = 4'(AES_NR);

  typedef logic [127:0] aes_key_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand,
    StDone
  } aes_state_e;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key store. AES_KEY_CACHE_EN keeps all 11 round keys; otherwise only the
// round-10 key (decrypt start key) is kept and returned for every read index.
module aes_rk_store
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] widx,
  input  aes_key_t   wdata,
  input  logic [3:0] ridx,
  output aes_key_t   rdata
);

`ifdef AES_KEY_CACHE_EN
  aes_key_t mem [AES_NRK];

  always_ff @(posedge clk) begin
    if (we && widx <= AES_NR_IDX) begin
      mem[widx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (ridx <= AES_NR_IDX) begin
      rdata = mem[ridx];
    end
  end
`else
  aes_key_t k10_q;

  always_ff @(posedge clk) begin
    if (we && widx == AES_NR_IDX) begin
      k10_q <= wdata;
    end
  end

  assign rdata = k10_q;

  logic unused_ridx;
  assign unused_ridx = ^ridx;
`endif

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key-schedule controller: accepts a cipher key, strobes the external expander and
// captures its 11 round keys. Build option AES_KEY_CACHE_EN selects the full key cache.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_vld,
  input  logic [127:0] key_in,
  output logic         key_rdy,
  output logic         kld,
  output logic [127:0] key_out,
  input  logic [127:0] rk_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         sched_done
);

  aes_state_e state_q;
  aes_key_t   key_q;
  logic [3:0] rcnt_q;
  logic       kld_q, busy_q, done_q, rdy_q;
  logic       accept;
  logic       rk_we;

  assign accept = key_vld && rdy_q;

  // Acceptance takes priority in every state so a reload aborts a running schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      rcnt_q  <= '0;
      kld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      kld_q <= 1'b0;
      if (accept) begin
        state_q <= StLoad;
        key_q   <= key_in;
        rcnt_q  <= '0;
        kld_q   <= 1'b1;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        rdy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StLoad: begin
            state_q <= StExpand;
            rcnt_q  <= '0;
            rdy_q   <= 1'b1;
          end
          StExpand: begin
            if (rcnt_q == AES_NR_IDX) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // An aborted schedule must not overwrite entries on the reload edge.
  assign rk_we = (state_q == StExpand) && !accept;

  aes_rk_store u_rk_store (
    .clk   (clk),
    .we    (rk_we),
    .widx  (rcnt_q),
    .wdata (rk_in),
    .ridx  (rd_idx),
    .rdata (rd_key)
  );

  assign key_rdy    = rdy_q;
  assign kld        = kld_q;
  assign key_out    = key_q;
  assign busy       = busy_q;
  assign sched_done = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES key expander feeding rk_in, a
// cycles-since-acceptance reference model, vector table, corner sequences, random run.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_vld;
  logic [127:0] key_in;
  logic         key_rdy;
  logic         kld;
  logic [127:0] key_out;
  logic [127:0] rk_in;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         busy;
  logic         sched_done;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_vld    (key_vld),
    .key_in     (key_in),
    .key_rdy    (key_rdy),
    .kld        (kld),
    .key_out    (key_out),
    .rk_in      (rk_in),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .busy       (busy),
    .sched_done (sched_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // One FIPS-197 key-expansion round: round r (1..10) from round r-1.
  function automatic logic [127:0] next_rk(input logic [127:0] prev, input int r);
    logic [7:0]  rc;
    logic [31:0] t, n0, n1, n2, n3;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
    t  = subword({prev[23:0], prev[31:24]}) ^ {rc, 24'h000000};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // External key expander: loads on kld, then steps one round per clock.
  logic [127:0] exp_w;
  int           exp_r = 10;
  always @(posedge clk) begin
    if (kld === 1'b1) begin
      exp_w <= key_out;
      exp_r <= 0;
    end else if (exp_r < 10) begin
      exp_w <= next_rk(exp_w, exp_r + 1);
      exp_r <= exp_r + 1;
    end
  end
  assign rk_in = exp_w;

  // Reference model: n_m = clock edges since the last accepted key (-1: none).
  int           n_m = -1;
  logic [127:0] key_m = '0;
  logic [127:0] rk_m [11];
  int           kld_cnt = 0;
  bit           done_seen = 1'b0;

  task automatic model_load(input logic [127:0] k);
    rk_m[0] = k;
    for (int r = 1; r <= 10; r++) rk_m[r] = next_rk(rk_m[r-1], r);
  endtask

  function automatic logic [127:0] exp_rd(input logic [3:0] idx);
`ifdef AES_KEY_CACHE_EN
    return (idx <= 4'd10) ? rk_m[idx] : 128'h0;
`else
    return rk_m[10];
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("kld", kld, n_m == 0);
    chk("key_rdy", key_rdy, n_m != 0);
    chk("busy", busy, n_m >= 0 && n_m < 12);
    chk("sched_done", sched_done, n_m >= 12);
    chk("key_out", key_out, key_m);
    if (n_m >= 12) chk("rd_key", rd_key, exp_rd(rd_idx));
  endtask

  task automatic tick();
    bit acc;
    acc = rst_n && key_vld && (n_m != 0);
    @(posedge clk);
    #1;
    if (acc) begin
      n_m   = 0;
      key_m = key_in;
      model_load(key_in);
    end else if (n_m >= 0 && n_m < 12) begin
      n_m++;
    end
    if (kld === 1'b1) kld_cnt++;
    if (sched_done === 1'b1) done_seen = 1'b1;
    check_all();
  endtask

  task automatic pulse_reset();
    key_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_m   = -1;
    key_m = '0;
    chk("rst kld", kld, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst sched_done", sched_done, 1'b0);
    chk("rst key_out", key_out, 128'h0);
    chk("rst key_rdy", key_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while (sched_done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk(name, cnt, 12);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] expv;
  } vec_t;

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K0R = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1R = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  vec_t vecs [4];

  initial begin
    int kbase;
    rst_n   = 1'b1;
    key_vld = 1'b0;
    key_in  = '0;
    rd_idx  = 4'd0;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] b, inv;
      b   = 8'(x);
      inv = (x == 0) ? 8'h00 : 8'h01;
      if (x != 0) for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{K0, 4'd10, K0R};
    vecs[1] = '{K1, 4'd10, K1R};
`ifdef AES_KEY_CACHE_EN
    vecs[2] = '{K1, 4'd0, K1};
    vecs[3] = '{K0, 4'd15, 128'h0};
`else
    vecs[2] = '{K1, 4'd0, K1R};
    vecs[3] = '{K0, 4'd15, K0R};
`endif

    #1;
    rst_n = 1'b0;
    #1;
    chk("init kld", kld, 1'b0);
    chk("init busy", busy, 1'b0);
    chk("init sched_done", sched_done, 1'b0);
    chk("init key_out", key_out, 128'h0);
    chk("init key_rdy", key_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table; acceptance cycle + LOAD + 11 EXPAND = 13 cycles to sched_done.
    for (int v = 0; v < 4; v++) begin
      key_vld = 1'b1;
      key_in  = vecs[v].key;
      rd_idx  = vecs[v].idx;
      tick();
      key_vld = 1'b0;
      wait_done("latency");
      chk("vector rd_key", rd_key, vecs[v].expv);
    end

    // Mid-schedule reload.
    kld_cnt   = 0;
    done_seen = 1'b0;
    key_vld   = 1'b1;
    key_in    = 128'h0;
    tick();
    key_vld = 1'b0;
    repeat (5) tick();
    key_vld = 1'b1;
    key_in  = K1;
    tick();
    key_vld = 1'b0;
    chk("reload kld count", kld_cnt, 2);
    chk("reload no early done", done_seen, 1'b0);
    rd_idx = 4'd10;
    wait_done("reload latency");
    chk("reload rd_key", rd_key, K1R);
    chk("reload kld total", kld_cnt, 2);

    // Read sweep over every index, including out-of-range ones.
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("sweep rd_key", rd_key, exp_rd(4'(i)));
    end

    // Back-to-back reloads every two cycles never let the schedule finish.
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key_vld = 1'b1;
      key_in  = (i % 2 == 0) ? {128{1'b1}} : 128'h0;
      tick();
      chk("alt busy load", busy, 1'b1);
      key_vld = 1'b0;
      tick();
      chk("alt busy expand", busy, 1'b1);
    end
    chk("alt no done", done_seen, 1'b0);

    // Reset in the middle of EXPAND.
    repeat (4) tick();
    pulse_reset();
    kld_cnt = 0;
    repeat (6) tick();
    chk("no kld after reset", kld_cnt, 0);

    // Random traffic against the model.
    kbase = 0;
    for (int c = 0; c < 600; c++) begin
      key_vld = ($urandom_range(0, 9) == 0);
      key_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rd_idx  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) pulse_reset();
      else tick();
      kbase++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
